// File: rtl/mux41_pkg.sv
// Shared types and constants for the 4:1 mux arbiter: FSM states, requester indices and
// the {S2,S1} select code each requester drives into the mux.
package mux41_pkg;

  typedef enum logic [0:0] {IDLE, XFER} state_e;

  localparam int unsigned REQ_A = 0;
  localparam int unsigned REQ_B = 1;
  localparam int unsigned REQ_C = 2;
  localparam int unsigned REQ_D = 3;

  localparam logic [1:0] SEL_A = 2'b11;
  localparam logic [1:0] SEL_B = 2'b10;
  localparam logic [1:0] SEL_C = 2'b01;
  localparam logic [1:0] SEL_D = 2'b00;

  function automatic logic [1:0] sel_code(input logic [1:0] idx);
    logic [1:0] code;
    case (idx)
      2'(REQ_A): code = SEL_A;
      2'(REQ_B): code = SEL_B;
      2'(REQ_C): code = SEL_C;
      default:   code = SEL_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request strictly after the last-granted
// index, in circular order A>B>C>D>A.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [3:0] win,
  output logic [1:0] idx
);

  logic [1:0] cand;
  logic       found;

  always_comb begin
    win   = '0;
    idx   = last;
    found = 1'b0;
    cand  = last;
    // i=4 wraps back to last itself, so a lone requester can be re-picked.
    for (int i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!found && req[cand]) begin
        found     = 1'b1;
        idx       = cand;
        win[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux41_arbiter.sv
// Round-robin arbiter/sequencer for the 4:1 mux with a one-entry valid/ready output stage.
// Optional ARB_LOCK_EN adds a LOCK input that keeps the grant across burst boundaries.
module mux41_arbiter
  import mux41_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BURST_MAX = 4
) (
`ifdef ARB_LOCK_EN
  input  logic             LOCK,
`endif
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [3:0]       REQ,
  output logic [3:0]       GNT,
  output logic             S1,
  output logic             S2,
  input  logic [WIDTH-1:0] MUX_Q,
  output logic [WIDTH-1:0] DOUT,
  output logic             OUT_VLD,
  input  logic             OUT_RDY,
  output logic             BUSY
);

  localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_MAX - 1);

  state_e             state_q, state_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         gidx_q, gidx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               settle_q, settle_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               vld_q, vld_d;

  logic [3:0]         win;
  logic [1:0]         win_idx;
  logic               req_g;
  logic               beat;
  logic               lock;

  rr_pick4 u_pick (
    .req  (REQ),
    .last (ptr_q),
    .win  (win),
    .idx  (win_idx)
  );

`ifdef ARB_LOCK_EN
  assign lock = LOCK;
`else
  assign lock = 1'b0;
`endif

  assign req_g = REQ[gidx_q];
  // The first XFER cycle only lets the mux settle after the select change.
  assign beat  = (state_q == XFER) && !settle_q && req_g && (!vld_q || OUT_RDY);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    dout_d   = dout_q;
    vld_d    = vld_q;

    if (beat) begin
      dout_d = MUX_Q;
      vld_d  = 1'b1;
    end else if (OUT_RDY) begin
      vld_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (|REQ) begin
          state_d  = XFER;
          gnt_d    = win;
          gidx_d   = win_idx;
          sel_d    = sel_code(win_idx);
          cnt_d    = '0;
          settle_d = 1'b1;
        end
      end
      XFER: begin
        settle_d = 1'b0;
        if (!req_g || (beat && (cnt_q == LAST_CNT) && !lock)) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = gidx_q;
        end else if (beat) begin
          cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      sel_q    <= SEL_D;
      ptr_q    <= 2'(REQ_D);
      gidx_q   <= 2'(REQ_A);
      cnt_q    <= '0;
      settle_q <= 1'b0;
      dout_q   <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      dout_q   <= dout_d;
      vld_q    <= vld_d;
    end
  end

  assign GNT     = gnt_q;
  assign S2      = sel_q[1];
  assign S1      = sel_q[0];
  assign DOUT    = dout_q;
  assign OUT_VLD = vld_q;
  assign BUSY    = (state_q == XFER);

endmodule
